// File: rtl/counter_seq_checker.sv
// Consumer-side monitor for a WIDTH-bit free-running counter. It samples
// cnt_in on each valid strobe and checks that every sample is the previous
// sample plus one, modulo 2^WIDTH. After RELOCK consecutive good increments
// it reports lock. While locked it pulses and counts sequence errors and
// counts max-to-zero wraps. Both counters saturate.
//
// Ports:
//   clk        - system clock; all state changes on the rising edge
//   rst        - asynchronous reset, active-low
//   cnt_in     - count value from the counter under check
//   cnt_valid  - cnt_in is sampled on a rising edge where this is 1
//   clear      - synchronous clear of counters and FSM (beats cnt_valid)
//   locked     - 1 while in LOCKED
//   err_pulse  - one-cycle pulse per detected sequence error
//   err_count  - saturating sequence-error count
//   wrap_count - saturating count of max-to-0 transitions seen while locked
//   expected   - next value the checker expects (0 in IDLE)
module counter_seq_checker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned WRAP_W     = 8,
  parameter int unsigned RELOCK     = 2,
  parameter bit          ALLOW_HOLD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  expected
);

  // RELOCK is limited to 1..15, so four bits always hold the run length.
  localparam int unsigned GOOD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]    err_count_q, err_count_d;
  logic [WRAP_W-1:0]   wrap_count_q, wrap_count_d;
  logic [WIDTH-1:0]    expected_q, expected_d;

  logic [WIDTH-1:0]    prev_inc;
  logic [GOOD_W-1:0]   good_inc;
  logic                match;
  logic                hold_ok;

  // Sequence comparison against the previous sample.
  always_comb begin
    prev_inc = prev_q + WIDTH'(1);
    good_inc = good_q + GOOD_W'(1);
    match    = (cnt_in == prev_inc);
    hold_ok  = ALLOW_HOLD && (cnt_in == prev_q);
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    good_d       = good_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;

    if (clear) begin
      // The sample on a clearing edge is discarded.
      state_d      = ST_IDLE;
      good_d       = '0;
      err_count_d  = '0;
      wrap_count_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cnt_valid) begin
            prev_d  = cnt_in;
            good_d  = '0;
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (cnt_valid) begin
            prev_d = cnt_in;
            if (match) begin
              good_d = good_inc;
              if (good_inc == GOOD_W'(RELOCK)) begin
                state_d = ST_LOCKED;
              end
            end else begin
              good_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (cnt_valid) begin
            if (match) begin
              prev_d = cnt_in;
              if ((prev_q == '1) && (wrap_count_q != '1)) begin
                wrap_count_d = wrap_count_q + WRAP_W'(1);
              end
            end else if (!hold_ok) begin
              err_pulse_d = 1'b1;
              if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_W'(1);
              end
              state_d = ST_SYNC;
              good_d  = '0;
              prev_d  = cnt_in;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          good_d  = '0;
        end
      endcase
    end

    locked_d   = (state_d == ST_LOCKED);
    expected_d = (state_d == ST_IDLE) ? '0 : prev_d + WIDTH'(1);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
      expected_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_q       <= good_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      expected_q   <= expected_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Bench for counter_seq_checker: two instances (ALLOW_HOLD=0 and =1) share
// the same stimulus and are compared each cycle against a behavioural model
// of the sampling/lock/error rules, plus directed constant checks.
module tb_counter_seq_checker;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned RELOCK = 2;
  localparam int          MODV   = 16;
  localparam int          SATV   = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt_in = '0;
  logic       cnt_valid = 1'b0;
  logic       clear = 1'b0;

  logic       locked0, err_pulse0, locked1, err_pulse1;
  logic [7:0] err_count0, wrap_count0, err_count1, wrap_count1;
  logic [3:0] expected0, expected1;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 = waiting for first sample, 1 = syncing, 2 = locked.
  int  m_phase [2];
  int  m_prev  [2];
  int  m_run   [2];
  int  m_err   [2];
  int  m_wrap  [2];
  bit  m_pulse [2];
  int  last_val;

  always #5 clk = ~clk;

  counter_seq_checker #(.WIDTH(WIDTH), .ERR_W(8), .WRAP_W(8), .RELOCK(RELOCK), .ALLOW_HOLD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clear(clear),
    .locked(locked0), .err_pulse(err_pulse0), .err_count(err_count0),
    .wrap_count(wrap_count0), .expected(expected0));

  counter_seq_checker #(.WIDTH(WIDTH), .ERR_W(8), .WRAP_W(8), .RELOCK(RELOCK), .ALLOW_HOLD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clear(clear),
    .locked(locked1), .err_pulse(err_pulse1), .err_count(err_count1),
    .wrap_count(wrap_count1), .expected(expected1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < 2; h++) begin
      m_phase[h] = 0; m_prev[h] = 0; m_run[h] = 0;
      m_err[h] = 0; m_wrap[h] = 0; m_pulse[h] = 1'b0;
    end
  endtask

  task automatic model_edge(input int h, input bit v, input int c, input bit clr);
    int nxt;
    m_pulse[h] = 1'b0;
    if (clr) begin
      m_phase[h] = 0; m_run[h] = 0; m_err[h] = 0; m_wrap[h] = 0;
      return;
    end
    if (!v) return;
    nxt = (m_prev[h] + 1) % MODV;
    if (m_phase[h] == 0) begin
      m_prev[h] = c; m_run[h] = 0; m_phase[h] = 1;
    end else if (m_phase[h] == 1) begin
      if (c == nxt) begin
        m_run[h]++;
        if (m_run[h] == RELOCK) m_phase[h] = 2;
      end else begin
        m_run[h] = 0;
      end
      m_prev[h] = c;
    end else begin
      if (c == nxt) begin
        if (m_prev[h] == MODV - 1 && c == 0 && m_wrap[h] < SATV) m_wrap[h]++;
        m_prev[h] = c;
      end else if (h == 1 && c == m_prev[h]) begin
        // repeated value tolerated by the hold-enabled instance
      end else begin
        m_pulse[h] = 1'b1;
        if (m_err[h] < SATV) m_err[h]++;
        m_phase[h] = 1; m_run[h] = 0; m_prev[h] = c;
      end
    end
  endtask

  function automatic int model_expected(input int h);
    return (m_phase[h] == 0) ? 0 : (m_prev[h] + 1) % MODV;
  endfunction

  task automatic check_all();
    chk("d0.locked",     32'(locked0),     32'(m_phase[0] == 2));
    chk("d0.err_pulse",  32'(err_pulse0),  32'(m_pulse[0]));
    chk("d0.err_count",  32'(err_count0),  32'(m_err[0]));
    chk("d0.wrap_count", 32'(wrap_count0), 32'(m_wrap[0]));
    chk("d0.expected",   32'(expected0),   32'(model_expected(0)));
    chk("d1.locked",     32'(locked1),     32'(m_phase[1] == 2));
    chk("d1.err_pulse",  32'(err_pulse1),  32'(m_pulse[1]));
    chk("d1.err_count",  32'(err_count1),  32'(m_err[1]));
    chk("d1.wrap_count", 32'(wrap_count1), 32'(m_wrap[1]));
    chk("d1.expected",   32'(expected1),   32'(model_expected(1)));
  endtask

  // Drive one edge's inputs, advance the model, and compare after the edge.
  task automatic step(input bit v, input int c, input bit clr);
    @(negedge clk);
    cnt_valid = v;
    cnt_in    = 4'(c);
    clear     = clr;
    @(posedge clk);
    model_edge(0, v, c, clr);
    model_edge(1, v, c, clr);
    if (v && !clr) last_val = c;
    #1;
    check_all();
  endtask

  initial begin
    int a, r, c;
    bit v, clr;
    model_reset();
    last_val = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // 1: clean count with a wrap
    for (int i = 0; i < 19; i++) begin
      step(1'b1, i % MODV, 1'b0);
      if (i == 2) chk("t1.locked_after_3rd", 32'(locked0), 32'd1);
      if (i == 16) chk("t1.wrap_after_15_0", 32'(wrap_count0), 32'd1);
    end
    chk("t1.err_count", 32'(err_count0), 32'd0);

    // 2: skip while locked, then relock
    step(1'b1, 3, 1'b0);
    step(1'b1, 4, 1'b0);
    step(1'b1, 5, 1'b0);
    step(1'b1, 7, 1'b0);
    chk("t2.err_pulse", 32'(err_pulse0), 32'd1);
    chk("t2.err_count", 32'(err_count0), 32'd1);
    chk("t2.locked",    32'(locked0),    32'd0);
    chk("t2.expected",  32'(expected0),  32'd8);
    step(1'b1, 8, 1'b0);
    chk("t2.pulse_drop", 32'(err_pulse0), 32'd0);
    step(1'b1, 9, 1'b0);
    chk("t2.relocked", 32'(locked0), 32'd1);

    // 3: invalid cycles are ignored
    step(1'b1, 10, 1'b0);
    step(1'b0, 10, 1'b0);
    step(1'b0, 9, 1'b0);
    step(1'b1, 11, 1'b0);
    chk("t3.no_err", 32'(err_count0), 32'd1);
    chk("t3.locked", 32'(locked0),    32'd1);

    // 4: repeated value with and without hold tolerance
    step(1'b1, 12, 1'b0);
    step(1'b1, 12, 1'b0);
    chk("t4.nohold_pulse", 32'(err_pulse0), 32'd1);
    chk("t4.hold_pulse",   32'(err_pulse1), 32'd0);
    step(1'b1, 13, 1'b0);
    chk("t4.hold_locked",   32'(locked1),   32'd1);
    chk("t4.hold_expected", 32'(expected1), 32'd14);

    // 5: saturate the error counter, then clear with a simultaneous sample
    for (int i = 0; i < 300; i++) begin
      a = last_val;
      step(1'b1, (a + 1) % MODV, 1'b0);
      step(1'b1, (a + 2) % MODV, 1'b0);
      step(1'b1, (a + 4) % MODV, 1'b0);
    end
    chk("t5.err_sat0", 32'(err_count0), 32'd255);
    chk("t5.err_sat1", 32'(err_count1), 32'd255);
    step(1'b1, 7, 1'b1);
    chk("t5.clr_err",      32'(err_count0),  32'd0);
    chk("t5.clr_wrap",     32'(wrap_count0), 32'd0);
    chk("t5.clr_locked",   32'(locked0),     32'd0);
    chk("t5.clr_expected", 32'(expected0),   32'd0);
    step(1'b1, 5, 1'b0);
    chk("t5.first_after_clr", 32'(expected0), 32'd6);

    // 6: asynchronous reset while locked
    for (int i = 6; i <= 16; i++) step(1'b1, i % MODV, 1'b0);
    chk("t6.pre_locked", 32'(locked0),     32'd1);
    chk("t6.pre_wrap",   32'(wrap_count0), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6.rst_locked", 32'(locked0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, i, 1'b0);
    chk("t6.relocked", 32'(locked0), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 99) < 2);
      v   = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 9);
      if (r < 7)       c = (last_val + 1) % MODV;
      else if (r == 7) c = last_val;
      else             c = $urandom_range(0, MODV - 1);
      step(v, c, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
